// File: rtl/chess_lab_engine_if.sv
// Bundle of the game-engine control and status signals between the board top level and chess_lab_engine.
// The master drives moves and commands. The slave reports the target, timer, scores and judgements.
interface chess_lab_engine_if #(
  parameter int N_PLAYERS = 2,
  parameter int TIME_W    = 8,
  parameter int SCORE_W   = 8
);
  logic                           iniciar;
  logic                           terminar;
  logic                           temJogada;
  logic [2:0]                     jogadaLinha;
  logic [2:0]                     jogadaColuna;
  logic [2:0]                     linhaEsperada;
  logic [2:0]                     colunaEsperada;
  logic [1:0]                     jogador;
  logic [TIME_W-1:0]              tempo;
  logic [N_PLAYERS*SCORE_W-1:0]   pontos;
  logic                           acertou;
  logic                           errou;
  logic                           fim;
  logic [3:0]                     db_estado;

  modport master (
    output iniciar, terminar, temJogada, jogadaLinha, jogadaColuna,
    input  linhaEsperada, colunaEsperada, jogador, tempo, pontos,
           acertou, errou, fim, db_estado
  );

  modport slave (
    input  iniciar, terminar, temJogada, jogadaLinha, jogadaColuna,
    output linhaEsperada, colunaEsperada, jogador, tempo, pontos,
           acertou, errou, fim, db_estado
  );
endinterface

// File: rtl/chess_lab_engine.sv
// N-player chess-square game engine: LFSR targets, per-turn countdown, move judging and per-player scores.
// Define CHESS_LAB_BCD_SCORE_EN to make scores count in packed BCD; otherwise they count in saturating binary.
module chess_lab_engine #(
  parameter int          N_PLAYERS  = 2,
  parameter int          TIME_W     = 8,
  parameter int          TIME_LIMIT = 100,
  parameter int          PENALTY    = 10,
  parameter int          TICK_DIV   = 1,
  parameter int          SCORE_W    = 8,
  parameter logic [5:0]  SEED       = 6'b000001
) (
  input  logic            clock,
  input  logic            reset,
  chess_lab_engine_if.slave bus
);

  typedef enum logic [3:0] {
    S_INICIAL = 4'd0,
    S_PREPARA = 4'd1,
    S_ESPERA  = 4'd2,
    S_COMPARA = 4'd3,
    S_ACERTO  = 4'd4,
    S_ERRO    = 4'd5,
    S_TROCA   = 4'd6,
    S_FIM     = 4'd7
  } state_t;

  localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0]  TIME_LOAD  = TIME_W'(TIME_LIMIT);
  localparam logic [TIME_W-1:0]  TIME_PEN   = TIME_W'(PENALTY);
  localparam logic [1:0]         LAST_P     = 2'(N_PLAYERS - 1);

  state_t                        r_state, w_next;
  logic [5:0]                    r_lfsr;
  logic [2:0]                    r_linha, r_coluna, r_mov_linha, r_mov_coluna;
  logic [1:0]                    r_jogador;
  logic [TIME_W-1:0]             r_tempo;
  logic [PRESC_W-1:0]            r_presc;
  logic [N_PLAYERS*SCORE_W-1:0]  r_pontos;
  logic                          r_tem_d;
  logic                          w_edge, w_expired, w_abort, w_draw, w_match;

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v);
`ifdef CHESS_LAB_BCD_SCORE_EN
    logic [SCORE_W-1:0] r;
    logic               carry;
    logic               all_nines;
    r         = v;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int d = 0; d < SCORE_W / 4; d++) begin
      if (v[4*d +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return all_nines ? v : r;
`else
    return (&v) ? v : v + SCORE_W'(1);
`endif
  endfunction

  assign w_edge    = bus.temJogada & ~r_tem_d;
  assign w_expired = (r_tempo == '0);
  assign w_match   = ({r_mov_linha, r_mov_coluna} == {r_linha, r_coluna});
  assign w_abort   = bus.terminar && (r_state != S_INICIAL) && (r_state != S_FIM);

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_next      = r_state;
    w_draw      = 1'b0;
    bus.acertou = 1'b0;
    bus.errou   = 1'b0;
    bus.fim     = 1'b0;
    if (w_abort) begin
      w_next = S_FIM;
    end else begin
      case (r_state)
        S_INICIAL: if (bus.iniciar) w_next = S_PREPARA;
        S_PREPARA: begin w_next = S_ESPERA; w_draw = 1'b1; end
        S_ESPERA: begin
          if (w_expired)   w_next = S_TROCA;
          else if (w_edge) w_next = S_COMPARA;
        end
        S_COMPARA: w_next = w_match ? S_ACERTO : S_ERRO;
        S_ACERTO:  begin w_next = S_ESPERA; w_draw = 1'b1; end
        S_ERRO:    w_next = S_ESPERA;
        S_TROCA: begin
          w_next = (r_jogador == LAST_P) ? S_FIM : S_ESPERA;
          w_draw = (r_jogador != LAST_P);
        end
        S_FIM:     if (bus.iniciar) w_next = S_PREPARA;
        default:   w_next = S_INICIAL;
      endcase
    end
    case (r_state)
      S_ACERTO: bus.acertou = 1'b1;
      S_ERRO:   bus.errou   = 1'b1;
      S_FIM:    bus.fim     = 1'b1;
      default:  ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_INICIAL;
      r_lfsr       <= SEED;
      r_linha      <= '0;
      r_coluna     <= '0;
      r_mov_linha  <= '0;
      r_mov_coluna <= '0;
      r_jogador    <= '0;
      r_tempo      <= '0;
      r_presc      <= '0;
      r_pontos     <= '0;
      r_tem_d      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tem_d <= bus.temJogada;
      if (w_draw) begin
        r_linha  <= r_lfsr[5:3];
        r_coluna <= r_lfsr[2:0];
        r_lfsr   <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
      end
      if (!w_abort) begin
        case (r_state)
          S_PREPARA: begin
            r_pontos  <= '0;
            r_jogador <= '0;
            r_tempo   <= TIME_LOAD;
          end
          S_ESPERA: begin
            // Expiry outranks a simultaneous move edge; the timer holds once it reaches zero.
            if (!w_expired) begin
              if (r_presc == PRESC_LAST) begin
                r_presc <= '0;
                r_tempo <= r_tempo - TIME_W'(1);
              end else begin
                r_presc <= r_presc + PRESC_W'(1);
              end
              if (w_edge) begin
                r_mov_linha  <= bus.jogadaLinha;
                r_mov_coluna <= bus.jogadaColuna;
              end
            end
          end
          S_ACERTO: begin
            for (int p = 0; p < N_PLAYERS; p++) begin
              if (r_jogador == 2'(p))
                r_pontos[p*SCORE_W +: SCORE_W] <= score_inc(r_pontos[p*SCORE_W +: SCORE_W]);
            end
          end
          S_ERRO: r_tempo <= (r_tempo > TIME_PEN) ? r_tempo - TIME_PEN : '0;
          S_TROCA: begin
            if (r_jogador != LAST_P) begin
              r_jogador <= r_jogador + 2'd1;
              r_tempo   <= TIME_LOAD;
            end
          end
          default: ;
        endcase
      end
      if ((w_next == S_ESPERA) && (r_state != S_ESPERA)) r_presc <= '0;
    end
  end

  assign bus.linhaEsperada  = r_linha;
  assign bus.colunaEsperada = r_coluna;
  assign bus.jogador        = r_jogador;
  assign bus.tempo          = r_tempo;
  assign bus.pontos         = r_pontos;
  assign bus.db_estado      = r_state;

endmodule

// File: tb/tb_chess_lab_engine.sv
// Scoreboard bench for chess_lab_engine: a slow-timer instance exercises judging and scores.
// A fast-timer instance exercises turn expiry and the end of the game.
module tb_chess_lab_engine;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chess_lab_engine_if #(.N_PLAYERS(2), .TIME_W(8), .SCORE_W(8)) if_a ();
  chess_lab_engine_if #(.N_PLAYERS(2), .TIME_W(8), .SCORE_W(8)) if_b ();

  chess_lab_engine #(
    .N_PLAYERS(2), .TIME_W(8), .TIME_LIMIT(100), .PENALTY(10),
    .TICK_DIV(1000), .SCORE_W(8), .SEED(6'b000001)
  ) u_a (.clock(clk), .reset(rst_a), .bus(if_a.slave));

  chess_lab_engine #(
    .N_PLAYERS(2), .TIME_W(8), .TIME_LIMIT(100), .PENALTY(10),
    .TICK_DIV(1), .SCORE_W(8), .SEED(6'b000001)
  ) u_b (.clock(clk), .reset(rst_b), .bus(if_b.slave));

  typedef struct {
    logic        hit;
    logic        post;
    int          cyc;
    logic [1:0]  jog;
    logic [15:0] pontos;
    logic [7:0]  tempo;
    logic [2:0]  lin;
    logic [2:0]  col;
  } exp_t;

  exp_t sb_q[$];

  logic [5:0] m_lfsr;
  logic [2:0] m_lin, m_col;
  logic [7:0] m_sc [2];
  logic [7:0] m_tempo;
  logic [1:0] m_jog;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sc_inc(input logic [7:0] v);
`ifdef CHESS_LAB_BCD_SCORE_EN
    if (v == 8'h99)          return v;
    else if (v[3:0] == 4'h9) return {v[7:4] + 4'd1, 4'h0};
    else                     return v + 8'd1;
`else
    return (v == 8'hFF) ? v : v + 8'd1;
`endif
  endfunction

  task automatic m_draw();
    m_lin  = m_lfsr[5:3];
    m_col  = m_lfsr[2:0];
    m_lfsr = {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
  endtask

  // Predict the judgement of one move on instance A, queue it, then issue a one-cycle strobe.
  task automatic move_a(input logic [2:0] l, input logic [2:0] c, input logic post);
    exp_t e;
    @(negedge clk);
    e.hit = (l == m_lin) && (c == m_col);
    if (e.hit) begin
      m_sc[m_jog] = sc_inc(m_sc[m_jog]);
      m_draw();
    end else begin
      m_tempo = (m_tempo > 8'd10) ? m_tempo - 8'd10 : 8'd0;
    end
    e.cyc    = cyc + 2;
    e.post   = post;
    e.jog    = m_jog;
    e.pontos = {m_sc[1], m_sc[0]};
    e.tempo  = m_tempo;
    e.lin    = m_lin;
    e.col    = m_col;
    sb_q.push_back(e);
    if_a.jogadaLinha  = l;
    if_a.jogadaColuna = c;
    if_a.temJogada    = 1'b1;
    @(negedge clk);
    if_a.temJogada = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_a.acertou || if_a.errou) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, if_a.acertou, if_a.errou}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind", if_a.acertou, e.hit);
          check("pulse_exclusive", if_a.acertou & if_a.errou, 1'b0);
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_jogador", if_a.jogador, e.jog);
          if (e.post) begin
            @(negedge clk);
            check("post_estado", if_a.db_estado, 4'd2);
            check("post_pontos", if_a.pontos, e.pontos);
            check("post_tempo", if_a.tempo, e.tempo);
            check("post_linha", if_a.linhaEsperada, e.lin);
            check("post_coluna", if_a.colunaEsperada, e.col);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int  k;
    logic found;
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.iniciar = 1'b0; if_a.terminar = 1'b0; if_a.temJogada = 1'b0;
    if_a.jogadaLinha = '0; if_a.jogadaColuna = '0;
    if_b.iniciar = 1'b0; if_b.terminar = 1'b0; if_b.temJogada = 1'b0;
    if_b.jogadaLinha = '0; if_b.jogadaColuna = '0;
    repeat (3) @(negedge clk);

    check("rst_estado", if_a.db_estado, 4'd0);
    check("rst_fim", if_a.fim, 1'b0);
    check("rst_pontos", if_a.pontos, 16'd0);
    check("rst_tempo", if_a.tempo, 8'd0);
    check("rst_target", {if_a.linhaEsperada, if_a.colunaEsperada}, 6'd0);
    check("rst_jogador", if_a.jogador, 2'd0);

    // Game start: first target (0,1), full timer.
    rst_a = 1'b0;
    m_lfsr = 6'b000001; m_sc[0] = 8'd0; m_sc[1] = 8'd0; m_jog = 2'd0;
    @(negedge clk); if_a.iniciar = 1'b1;
    @(negedge clk); if_a.iniciar = 1'b0;
    check("start_prepara", if_a.db_estado, 4'd1);
    m_draw(); m_tempo = 8'd100;
    @(negedge clk);
    check("start_espera", if_a.db_estado, 4'd2);
    check("start_target", {if_a.linhaEsperada, if_a.colunaEsperada}, {3'd0, 3'd1});
    check("start_tempo", if_a.tempo, 8'd100);
    check("start_pontos", if_a.pontos, 16'd0);

    move_a(3'd0, 3'd1, 1'b1); repeat (4) @(negedge clk);
    check("hit1_score", if_a.pontos[7:0], 8'd1);
    check("hit1_target", {if_a.linhaEsperada, if_a.colunaEsperada}, {3'd0, 3'd2});
    move_a(3'd0, 3'd2, 1'b1); repeat (4) @(negedge clk);
    check("hit2_target", {if_a.linhaEsperada, if_a.colunaEsperada}, {3'd0, 3'd4});

    for (int i = 0; i < 98; i++) begin
      move_a(m_lin, m_col, 1'b1); repeat (3) @(negedge clk);
`ifdef CHESS_LAB_BCD_SCORE_EN
      if (i == 7) check("ten_hits", if_a.pontos[7:0], 8'h10);
`else
      if (i == 7) check("ten_hits", if_a.pontos[7:0], 8'h0A);
`endif
    end
`ifdef CHESS_LAB_BCD_SCORE_EN
    check("hundred_hits", if_a.pontos[7:0], 8'h99);
`else
    check("hundred_hits", if_a.pontos[7:0], 8'h64);
`endif

    // Ten misses drain 100 ticks; the last one forces the turn over.
    for (int i = 0; i < 10; i++) begin
      move_a(~m_lin, m_col, 1'b1); repeat (3) @(negedge clk);
      if (i == 4) check("miss_tempo50", if_a.tempo, 8'd50);
      if (i == 5) check("miss_tempo40", if_a.tempo, 8'd40);
    end
    @(negedge clk);
    m_jog = 2'd1; m_tempo = 8'd100; m_draw();
    check("troca_estado", if_a.db_estado, 4'd2);
    check("troca_jogador", if_a.jogador, 2'd1);
    check("troca_tempo", if_a.tempo, 8'd100);
    check("troca_target", {if_a.linhaEsperada, if_a.colunaEsperada}, {m_lin, m_col});

    move_a(m_lin, m_col, 1'b1); repeat (3) @(negedge clk);
    check("p1_score", if_a.pontos[15:8], 8'd1);

    // Abort while the move is being compared: no judgement, scores held.
    @(negedge clk);
    if_a.jogadaLinha = m_lin; if_a.jogadaColuna = m_col; if_a.temJogada = 1'b1;
    @(negedge clk);
    if_a.temJogada = 1'b0;
    check("abort_compara", if_a.db_estado, 4'd3);
    if_a.terminar = 1'b1;
    @(negedge clk);
    if_a.terminar = 1'b0;
    check("abort_fim_estado", if_a.db_estado, 4'd7);
    check("abort_fim_flag", if_a.fim, 1'b1);
    repeat (3) @(negedge clk);
    check("fim_hold_estado", if_a.db_estado, 4'd7);
    check("fim_hold_pontos", if_a.pontos, {m_sc[1], m_sc[0]});

    // Second game from FIM continues the LFSR sequence.
    if_a.iniciar = 1'b1;
    @(negedge clk); if_a.iniciar = 1'b0;
    @(negedge clk);
    m_sc[0] = 8'd0; m_sc[1] = 8'd0; m_jog = 2'd0; m_tempo = 8'd100; m_draw();
    check("game2_pontos", if_a.pontos, 16'd0);
    check("game2_target", {if_a.linhaEsperada, if_a.colunaEsperada}, {m_lin, m_col});

    // Reset while in ACERTO.
    move_a(m_lin, m_col, 1'b0);
    @(negedge clk);
    check("pre_reset_acerto", if_a.db_estado, 4'd4);
    rst_a = 1'b1;
    @(negedge clk);
    check("mid_rst_estado", if_a.db_estado, 4'd0);
    check("mid_rst_pontos", if_a.pontos, 16'd0);
    check("mid_rst_tempo", if_a.tempo, 8'd0);
    check("mid_rst_target", {if_a.linhaEsperada, if_a.colunaEsperada}, 6'd0);
    check("mid_rst_jogador", if_a.jogador, 2'd0);
    check("mid_rst_acertou", if_a.acertou, 1'b0);
    rst_a = 1'b0;
    @(negedge clk); if_a.iniciar = 1'b1;
    @(negedge clk); if_a.iniciar = 1'b0;
    @(negedge clk);
    check("game3_target", {if_a.linhaEsperada, if_a.colunaEsperada}, {3'd0, 3'd1});
    check("sb_drained", sb_q.size(), 32'd0);

    // Instance B: one tick per clock.
    rst_b = 1'b0;
    @(negedge clk); if_b.iniciar = 1'b1;
    @(negedge clk); if_b.iniciar = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (if_b.tempo == 8'd8 && if_b.db_estado == 4'd2) found = 1'b1;
    end
    check("b_reach_tempo8", found, 1'b1);
    if_b.jogadaLinha = 3'd7; if_b.jogadaColuna = 3'd7; if_b.temJogada = 1'b1;
    @(negedge clk);
    if_b.temJogada = 1'b0;
    check("b_compara", if_b.db_estado, 4'd3);
    check("b_compara_tempo", if_b.tempo, 8'd7);
    @(negedge clk);
    check("b_errou", if_b.errou, 1'b1);
    @(negedge clk);
    check("b_penalty_floor", if_b.tempo, 8'd0);
    @(negedge clk);
    check("b_troca", if_b.db_estado, 4'd6);
    @(negedge clk);
    check("b_p1_jogador", if_b.jogador, 2'd1);
    check("b_p1_tempo", if_b.tempo, 8'd100);

    k = 0;
    while (if_b.tempo != 8'd0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("b_turn_ticks", k, 32'd100);
    if_b.jogadaLinha = if_b.linhaEsperada; if_b.jogadaColuna = if_b.colunaEsperada;
    if_b.temJogada = 1'b1;
    @(negedge clk);
    if_b.temJogada = 1'b0;
    check("b_expiry_wins", if_b.db_estado, 4'd6);
    check("b_no_judge1", if_b.acertou | if_b.errou, 1'b0);
    @(negedge clk);
    check("b_fim_estado", if_b.db_estado, 4'd7);
    check("b_fim_flag", if_b.fim, 1'b1);
    check("b_no_judge2", if_b.acertou | if_b.errou, 1'b0);
    repeat (3) @(negedge clk);
    check("b_fim_hold", if_b.db_estado, 4'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
